// File: rtl/instr_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_resp
// Summary  : Instruction-memory responder with a pipelined word read, an
//            in-order output FIFO, halt back-pressure, branch flush and a
//            preload write port. Optional macro IMEM_OOB_FAULT_EN turns
//            pc >= DEPTH into a faulting NOP entry instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif

module instr_mem_resp #(
    parameter int          XLEN       = `XLEN,
    parameter int          DEPTH      = 256,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] NOP        = 32'h0000_0013,
    parameter int          FIFO_DEPTH = RD_LATENCY + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          pc,
    input  logic                     mem_read_en,
    input  logic                     taken_branch,
    input  logic                     id_stall,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    output logic [31:0]              instr,
    output logic [XLEN-1:0]          instr_pc,
    output logic                     instr_valid,
    output logic                     instr_fault,
    output logic                     halt
);

    localparam int c_aw   = $clog2(DEPTH);
    localparam int c_nstg = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
    localparam int c_cw   = $clog2(FIFO_DEPTH + 1);
    localparam int c_pw   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
        logic            fault;
    } entry_t;

    logic [31:0]     r_mem [DEPTH];
    entry_t          r_fifo [FIFO_DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_cnt;

    entry_t          w_new_ent;
    entry_t          w_push_ent;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_oob;
    logic [c_cw-1:0] w_inflight;
    logic [c_cw-1:0] w_occ;
    logic [c_pw-1:0] w_wr_idx;

    // Memory array is deliberately left out of reset so preloads survive it.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

`ifdef IMEM_OOB_FAULT_EN
    assign w_oob = |(pc >> c_aw);
`else
    logic w_unused_pc;
    assign w_oob       = 1'b0;
    assign w_unused_pc = ^(pc >> c_aw);
`endif

    always_comb begin
        w_new_ent.pc    = pc;
        w_new_ent.fault = w_oob;
        w_new_ent.data  = w_oob ? NOP : r_mem[pc[c_aw-1:0]];
    end

    assign w_accept = mem_read_en & ~halt;

    generate
        if (RD_LATENCY > 1) begin : g_pipe
            logic [c_nstg-1:0] r_stg_vld;
            entry_t            r_stg [c_nstg];

            // Stage 0 always takes the newly accepted request, so a branch
            // target survives the flush that kills the older stages.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_stg_vld <= '0;
                end else begin
                    r_stg_vld[0] <= w_accept;
                    for (int i = 1; i < c_nstg; i++) begin
                        r_stg_vld[i] <= r_stg_vld[i-1] & ~taken_branch;
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_stg[0] <= w_new_ent;
                for (int i = 1; i < c_nstg; i++) begin
                    r_stg[i] <= r_stg[i-1];
                end
            end

            assign w_push     = r_stg_vld[c_nstg-1] & ~taken_branch;
            assign w_push_ent = r_stg[c_nstg-1];
            assign w_inflight = c_cw'($countones(r_stg_vld));
        end else begin : g_direct
            assign w_push     = w_accept;
            assign w_push_ent = w_new_ent;
            assign w_inflight = '0;
        end
    endgenerate

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // On a flush the FIFO restarts at slot 0, holding only a surviving push.
    assign w_wr_idx = taken_branch ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[w_wr_idx] <= w_push_ent;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (taken_branch) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? ptr_inc('0) : '0;
            r_cnt    <= w_push ? c_cw'(1) : '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cnt <= r_cnt + c_cw'(w_push) - c_cw'(w_pop);
        end
    end

    assign instr_valid = (r_cnt != '0);
    assign w_pop       = instr_valid & ~id_stall;
    assign w_occ       = w_inflight + r_cnt;
    assign halt        = ~taken_branch &
                         ((w_occ - c_cw'(w_pop)) >= c_cw'(FIFO_DEPTH));

    always_comb begin
        instr       = NOP;
        instr_pc    = '0;
        instr_fault = 1'b0;
        if (instr_valid) begin
            instr       = r_fifo[r_rd_ptr].data;
            instr_pc    = r_fifo[r_rd_ptr].pc;
            instr_fault = r_fifo[r_rd_ptr].fault;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_resp
// Summary  : Drives a latency-1 and a latency-3 instr_mem_resp with shared
//            directed and random stimulus, compared against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_resp;

    localparam int          NI    = 2;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        mem_read_en;
    logic        taken_branch;
    logic        id_stall;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    logic [31:0] d_instr [NI];
    logic [31:0] d_pc    [NI];
    logic        d_valid [NI];
    logic        d_fault [NI];
    logic        d_halt  [NI];

    always #5 clk = ~clk;

    instr_mem_resp #(
        .XLEN(32), .DEPTH(DEPTH), .RD_LATENCY(1), .NOP(NOP)
    ) u_dut_l1 (
        .clk(clk), .rst(rst), .pc(pc), .mem_read_en(mem_read_en),
        .taken_branch(taken_branch), .id_stall(id_stall), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .instr(d_instr[0]),
        .instr_pc(d_pc[0]), .instr_valid(d_valid[0]),
        .instr_fault(d_fault[0]), .halt(d_halt[0])
    );

    instr_mem_resp #(
        .XLEN(32), .DEPTH(DEPTH), .RD_LATENCY(3), .NOP(NOP)
    ) u_dut_l3 (
        .clk(clk), .rst(rst), .pc(pc), .mem_read_en(mem_read_en),
        .taken_branch(taken_branch), .id_stall(id_stall), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .instr(d_instr[1]),
        .instr_pc(d_pc[1]), .instr_valid(d_valid[1]),
        .instr_fault(d_fault[1]), .halt(d_halt[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: an ordered list of outstanding requests per instance,
    // each aging by one per edge and visible once it has aged RD_LATENCY-1.
    logic [31:0] mem_m [DEPTH];
    int          m_n   [NI];
    logic [31:0] m_pc  [NI][8];
    logic [31:0] m_dat [NI][8];
    logic        m_flt [NI][8];
    int          m_age [NI][8];
    bit          m_halt [NI];
    bit          m_acc  [NI];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit head_vis(input int k);
        return (m_n[k] > 0) && (m_age[k][0] >= lat_of(k) - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) m_n[k] = 0;
    endtask

    task automatic model_comb();
        for (int k = 0; k < NI; k++) begin
            int pop;
            pop = (head_vis(k) && !id_stall) ? 1 : 0;
            m_halt[k] = !taken_branch && ((m_n[k] - pop) >= lat_of(k) + 1);
            m_acc[k]  = mem_read_en && !m_halt[k];
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NI; k++) begin
            bit vis;
            int l;
            vis = head_vis(k);
            l   = lat_of(k);
            check($sformatf("valid_l%0d", l), d_valid[k], vis);
            check($sformatf("instr_l%0d", l), d_instr[k], vis ? m_dat[k][0] : NOP);
            check($sformatf("pc_l%0d", l), d_pc[k], vis ? m_pc[k][0] : 32'd0);
            check($sformatf("fault_l%0d", l), d_fault[k], vis ? m_flt[k][0] : 1'b0);
            check($sformatf("halt_l%0d", l), d_halt[k], m_halt[k]);
        end
    endtask

    task automatic model_edge();
        logic [31:0] nd;
        logic        nf;
        bit          oob;
        oob = (pc >= DEPTH);
`ifdef IMEM_OOB_FAULT_EN
        nd = oob ? NOP : mem_m[pc[7:0]];
        nf = oob;
`else
        nd = mem_m[pc[7:0]];
        nf = 1'b0;
`endif
        for (int k = 0; k < NI; k++) begin
            if (head_vis(k) && !id_stall) begin
                for (int i = 1; i < m_n[k]; i++) begin
                    m_pc[k][i-1]  = m_pc[k][i];
                    m_dat[k][i-1] = m_dat[k][i];
                    m_flt[k][i-1] = m_flt[k][i];
                    m_age[k][i-1] = m_age[k][i];
                end
                m_n[k]--;
            end
            if (taken_branch) m_n[k] = 0;
            for (int i = 0; i < m_n[k]; i++) m_age[k][i]++;
            if (m_acc[k]) begin
                m_pc[k][m_n[k]]  = pc;
                m_dat[k][m_n[k]] = nd;
                m_flt[k][m_n[k]] = nf;
                m_age[k][m_n[k]] = 0;
                m_n[k]++;
            end
        end
        if (ld_en) mem_m[ld_addr] = ld_data;
    endtask

    // One clock: drive at the falling edge, check just after, model the edge.
    task automatic cyc(input logic [31:0] p, input bit re, input bit tb_,
                       input bit st, input bit le, input logic [7:0] la,
                       input logic [31:0] ldd);
        pc           = p;
        mem_read_en  = re;
        taken_branch = tb_;
        id_stall     = st;
        ld_en        = le;
        ld_addr      = la;
        ld_data      = ldd;
        #1;
        model_comb();
        check_outputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] p;
        rst = 1'b0;
        pc = '0; mem_read_en = 1'b0; taken_branch = 1'b0; id_stall = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        model_comb();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        for (int a = 0; a < DEPTH; a++)
            cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(a), $urandom);

        // Streaming
        for (int i = 0; i < 4; i++) cyc(32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(4);

        // Back-pressure with fetch holding pc while halted
        p = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(p, 1'b1, 1'b0, (i < 4), 1'b0, 8'd0, 32'd0);
            if (m_acc[0]) p++;
        end
        idle(5);

        // Flush of older reads by a branch target
        cyc(32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        cyc(32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        cyc(32'd8, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(5);
        cyc(32'd9, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0);
        cyc(32'd12, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(4);

        // Out-of-range request, plus same-address preload in the same cycle
        cyc(32'd258, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        cyc(32'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 32'hDEAD_BEEF);
        cyc(32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(5);

        // Asynchronous reset while full and stalled
        p = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(p, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0);
            if (m_acc[0]) p++;
        end
        #2;
        rst = 1'b0;
        mem_read_en = 1'b0; id_stall = 1'b0;
        #1;
        model_reset();
        model_comb();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        cyc(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(4);

        // Random traffic
        p = 0;
        for (int n = 0; n < 3000; n++) begin
            bit re, tb_, st, le;
            logic [7:0] la;
            re  = ($urandom_range(7) != 0);
            tb_ = ($urandom_range(11) == 0);
            st  = ($urandom_range(2) == 0);
            if (tb_) p = ($urandom_range(9) == 0) ? 32'(256 + $urandom_range(40))
                                                  : 32'($urandom_range(255));
            le  = ($urandom_range(3) == 0);
            la  = $urandom_range(1) ? p[7:0] : 8'($urandom_range(255));
            cyc(p, re, tb_, st, le, la, $urandom);
            if (m_acc[0]) p++;
            if (p > 300) p = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_mem_resp.md
Name: instr_mem_resp

Overview:
Instruction-memory responder serving the fetch stage's word-indexed read requests (pc, mem_read_en) and returning instructions in order to decode.
- Pipelined read of configurable latency.
- In-order output FIFO with back-pressure from decode.
- Generates halt back to fetch; flushes stale reads on taken_branch.
- Includes a preload write port for test/boot.

Parameters:
- XLEN, `XLEN: address/pc width.
- DEPTH, 256: memory words (power of 2); AW = $clog2(DEPTH).
- RD_LATENCY, 1: read pipeline stages, legal 1..3.
- NOP, 32'h00000013: instruction driven when empty or faulted.
- FIFO_DEPTH, RD_LATENCY+1: output FIFO entries.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pc  in  XLEN  word index requested by fetch.
- mem_read_en  in  1  request valid.
- taken_branch  in  1  current pc is a branch target; flush older reads.
- id_stall  in  1  decode not accepting this cycle.
- ld_en  in  1  preload write enable.
- ld_addr  in  AW  preload word address.
- ld_data  in  32  preload data.
- instr  out  32  FIFO head instruction.
- instr_pc  out  XLEN  pc of the head entry.
- instr_valid  out  1  head entry valid.
- instr_fault  out  1  head entry out-of-range (see Optional Feature).
- halt  out  1  fetch must hold pc.

Behaviour:
- Reset (async, rst=0):
  - Clear pipeline valids, FIFO pointers and occupancy.
  - Outputs: instr=NOP, instr_pc=0, instr_valid=0, instr_fault=0, halt=0.
  - Memory array is not reset; contents survive reset.
- Accept:
  - A request is accepted at the rising edge when rst=1, mem_read_en=1 and halt=0.
  - Accepted requests are tagged with pc.
- Latency:
  - A request accepted at edge N is written into the FIFO at edge N+RD_LATENCY-1.
  - It is visible on the outputs after that edge, i.e. one cycle after acceptance when RD_LATENCY=1.
  - Order is always preserved.
- Occupancy:
  - occ = in-flight stage count + FIFO count, in range 0..FIFO_DEPTH.
  - pop = instr_valid & !id_stall.
  - halt = !taken_branch & ((occ - pop) >= FIFO_DEPTH).
  - halt is combinational from registers plus id_stall/taken_branch only; there is no path from pc.
  - Full throughput (1 instr/cycle) is sustained when id_stall=0.
- Output:
  - instr, instr_pc and instr_fault reflect the FIFO head.
  - When the FIFO is empty: instr=NOP, instr_pc=0, instr_fault=0, instr_valid=0.
  - The head entry pops at the edge where pop=1.
- Flush:
  - If taken_branch=1, at that edge invalidate all in-flight stages and all FIFO entries.
  - The request accepted in the same cycle (the branch target) is kept.
  - A pop in the flush cycle is still consumed by decode.
  - After the flush, the first instr_valid carries instr_pc = target pc.
- Simultaneous events:
  - Push and pop at the same edge leave the count unchanged.
  - Flush overrides push of older stages.
  - Flush with mem_read_en=0 leaves occ=0.
- Preload:
  - ld_en writes mem[ld_addr]=ld_data at the edge.
  - Read of the same address in the same cycle returns the old data.
  - ld_en is independent of halt.
- Address: a request is in range when pc < DEPTH.

Optional Feature:
Macro: IMEM_OOB_FAULT_EN.
- Defined: a request with pc >= DEPTH does not read memory. Its entry carries instr=NOP and instr_fault=1; it is otherwise ordered and flushed like any other entry.
- Undefined: the index is pc[AW-1:0] (wrap-around), and instr_fault is tied to 0.

Test Plan:
1. Streaming: preload mem[0..3]=A0..A3, RD_LATENCY=1, pc=0,1,2,3 on consecutive cycles, id_stall=0 -> instr A0..A3 on 4 consecutive cycles starting one cycle after the first accept; instr_pc 0..3; halt never 1.
2. Back-pressure: stream pc=0.. with id_stall=1 for 4 cycles -> halt rises once occ reaches 2; fetch holds pc; after release, A0,A1,A2... arrive with no loss or duplication.
3. Flush: two reads (pc 4,5) in flight, then taken_branch=1 with pc=8 (mem[8]=B8) -> pc 4/5 never valid; next instr_valid has instr=B8, instr_pc=8.
4. Out of range: pc=258 with DEPTH=256 and mem[2]=A2 -> without macro instr=A2, instr_fault=0; with IMEM_OOB_FAULT_EN instr=32'h00000013, instr_fault=1.
5. Reset mid-operation: FIFO full with id_stall=1, drop rst -> instr_valid=0, halt=0, instr=NOP immediately (async); after release, pc=0 returns A0 (memory retained).
6. Latency: RD_LATENCY=3, single request pc=1 -> instr_valid rises exactly 3 cycles after acceptance; FIFO_DEPTH=4 entries absorb a 4-cycle id_stall with no drop.
